// File: rtl/sha256_msg_mem.sv
// Word-addressed message/digest memory shared by a host port and the SHA-256 engine.
// Optional macro SHA_MEM_ADDR_CHECK_EN enables host range checking (addr_err, dropped writes, 32'hDEADBEEF reads).
module sha256_msg_mem #(
  parameter int AW   = 8,
  parameter int NDIG = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eng_start,
  input  logic        eng_done,
  input  logic        eng_we,
  input  logic [15:0] eng_addr,
  input  logic [31:0] eng_wdata,
  output logic [31:0] eng_rdata,
  input  logic [15:0] out_base,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic        busy,
  output logic        digest_ready,
  output logic        addr_err
);

  localparam int DEPTH = 1 << AW;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ENGINE = 1'b1;

  logic [0:0]      state;
  logic [NDIG-1:0] mask;
  logic [NDIG-1:0] mask_set;
  logic [15:0]     dig_off;
  logic [AW-1:0]   eng_idx;
  logic [AW-1:0]   host_idx;
  logic            host_accept;
  logic            host_range_ok;
  logic            host_wr_en;
  logic [31:0]     host_rd_word;

  logic [31:0] mem [DEPTH];

  assign eng_idx  = eng_addr[AW-1:0];
  assign host_idx = host_addr[AW-1:0];
  assign busy     = (state == ENGINE);

  // Digest window offset wraps at 16 bits, so a window straddling 0xFFFF still tracks correctly.
  always_comb begin
    dig_off  = eng_addr - out_base;
    mask_set = '0;
    if (eng_we) begin
      for (int i = 0; i < NDIG; i++) begin
        if (dig_off == 16'(i)) begin
          mask_set[i] = 1'b1;
        end
      end
    end
  end

  // An ack cycle is never an accept cycle, which limits the host to one transaction per two cycles.
  assign host_accept = (state == IDLE) && !eng_start && host_req && !host_ack;

`ifdef SHA_MEM_ADDR_CHECK_EN
  assign host_range_ok = (host_addr[15:AW] == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (host_accept && !host_range_ok) begin
      addr_err <= 1'b1;
    end
  end
`else
  logic unused_host_upper;

  assign host_range_ok     = 1'b1;
  assign unused_host_upper = |host_addr[15:AW];
  assign addr_err          = 1'b0;
`endif

  assign host_wr_en   = host_accept && host_we && host_range_ok;
  assign host_rd_word = host_range_ok ? mem[host_idx] : 32'hDEADBEEF;

  // Storage is deliberately not reset so a loaded message survives a reset; engine write wins a same-index collision.
  always_ff @(posedge clk) begin
    if (host_wr_en) begin
      mem[host_idx] <= host_wdata;
    end
    if (eng_we) begin
      mem[eng_idx] <= eng_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mask         <= '0;
      digest_ready <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      eng_rdata    <= '0;
    end else begin
      eng_rdata <= mem[eng_idx];
      host_ack  <= host_accept;
      if (host_accept) begin
        host_rdata <= host_rd_word;
      end

      case (state)
        IDLE: begin
          if (eng_start) begin
            state        <= ENGINE;
            mask         <= '0;
            digest_ready <= 1'b0;
          end
        end
        ENGINE: begin
          if (eng_start) begin
            mask         <= '0;
            digest_ready <= 1'b0;
          end else if (eng_done) begin
            state        <= IDLE;
            mask         <= mask | mask_set;
            digest_ready <= &(mask | mask_set);
          end else begin
            mask <= mask | mask_set;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
